// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential divider.
package div_pkg;

  // Default operand / result width of the divider.
  localparam int DIV_WIDTH_DEFAULT = 4;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : div_pkg

// File: rtl/trial_sub.sv
// Trial subtractor for the restoring divider: a - b built from ripple
// full-adder cells, with b inverted and a carry-in of 1. borrow_o is the
// inverted final carry, so it is set exactly when b > a.

// One-bit full-adder cell of the ripple adders.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  // Sum and carry of one bit position.
  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  end

endmodule : full_adder

module trial_sub #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0]   carry;
  logic [N-1:0] b_inv;

  assign carry[0] = 1'b1;
  assign b_inv    = ~b_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_inv[i]),
      .c_i (carry[i]),
      .s_o (diff_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign borrow_o = ~carry[N];

endmodule : trial_sub

// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
//
// Handshake: start acts as a valid with an implicit ready of
// (state is IDLE or DONE), i.e. !busy. A start is accepted on the rising
// edge where start=1 and the divider is not busy; a start seen while busy
// is dropped and the operands are not resampled. done is a one-cycle pulse
// marking the first cycle the results are valid; the results then stay put
// until the next accepted start.
module div4_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_e           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;       // partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // dividend in, quotient out shift register
  logic [WIDTH-1:0] dvs_q, dvs_d;   // latched divisor
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             last_iter;
  logic             dvs_zero_in;
  logic [WIDTH-1:0] p_shift;
  logic [WIDTH:0]   t_diff;
  logic             t_borrow;
  logic [WIDTH-1:0] p_iter;
  logic [WIDTH-1:0] q_iter;
  logic             unused_diff_msb;

  assign accept      = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_iter   = (cnt_q == CW'(WIDTH - 1));
  assign dvs_zero_in = (divisor == '0);

  // P has fewer significant bits than the iteration count, so its MSB is
  // always zero before the shift and dropping it loses nothing.
  assign p_shift = {p_q[WIDTH-2:0], q_q[WIDTH-1]};

  trial_sub #(
    .N (WIDTH + 1)
  ) u_trial_sub (
    .a_i      ({1'b0, p_shift}),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (t_diff),
    .borrow_o (t_borrow)
  );

  // With no borrow the difference fits in WIDTH bits; its top bit is zero.
  assign unused_diff_msb = t_diff[WIDTH];
  assign p_iter = t_borrow ? p_shift : t_diff[WIDTH-1:0];
  assign q_iter = {q_q[WIDTH-2:0], ~t_borrow};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: zero divisor skips straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = dvs_zero_in ? DONE : RUN;
      RUN:  if (last_iter) state_d = DONE;
      DONE: begin
        if (start) state_d = dvs_zero_in ? DONE : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Datapath next-state: operand capture, one restoring step per RUN cycle.
  always_comb begin
    cnt_d = cnt_q;
    p_d   = p_q;
    q_d   = q_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d  = dz_q;
    if (accept) begin
      cnt_d = '0;
      p_d   = '0;
      q_d   = dividend;
      dvs_d = divisor;
      quo_d = dvs_zero_in ? '1 : '0;
      rem_d = dvs_zero_in ? dividend : '0;
      dz_d  = dvs_zero_in;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CW'(1);
      p_d   = p_iter;
      q_d   = q_iter;
      if (last_iter) begin
        quo_d = q_iter;
        rem_d = p_iter;
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      p_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
      q_q   <= q_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q  <= dz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule : div4_seq

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq at the default width of 4.
module tb_div4_seq;
  import div_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  state_e       dbg_state;

  div4_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [31:0]  due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && done) begin
      check("busy_done_excl", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", 32'(quotient), 32'(mon_e.q));
        check("remainder", 32'(remainder), 32'(mon_e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
        check("latency", 32'(cyc), mon_e.due);
        if (mon_e.b != '0) begin
          check("invariant", 32'(quotient) * 32'(mon_e.b) + 32'(remainder), 32'(mon_e.a));
          check("rem_lt_div", 32'(remainder < mon_e.b), 32'd1);
        end
      end
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.dz  = (b == '0);
    e.q   = (b == '0) ? {W{1'b1}} : W'(a / b);
    e.r   = (b == '0) ? a : W'(a % b);
    e.due = 32'(cyc + 1 + ((b == '0) ? 0 : W));
    exp_q.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Drives start without an expectation: used while the divider is busy.
  task automatic poke_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the falling edge where done is seen, or flags a timeout.
  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic operation and busy right after acceptance.
    start_op(4'd13, 4'd3);
    @(negedge clk);
    check("run_busy", 32'(busy), 32'd1);
    check("run_done", 32'(done), 32'd0);
    wait_done();
    start_op(4'd3, 4'd7);
    wait_done();
    start_op(4'd15, 4'd1);
    wait_done();

    // Divide by zero: one-cycle latency, busy never raised.
    start_op(4'd9, 4'd0);
    check("dz_busy", 32'(busy), 32'd0);
    wait_done();

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    start_op(4'd12, 4'd5);
    @(negedge clk);
    check("busy_at_poke", 32'(busy), 32'd1);
    poke_start(4'd15, 4'd15);
    wait_done();
    start_op(4'd15, 4'd15);
    wait_done();

    // Asynchronous reset in the middle of RUN.
    start_op(4'd12, 4'd5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_quotient", 32'(quotient), 32'd0);
    check("mid_rst_remainder", 32'(remainder), 32'd0);
    check("mid_rst_dz", 32'(div_by_zero), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    start_op(4'd7, 4'd2);
    wait_done();

    // Exhaustive sweep, issued back-to-back from each DONE cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(W'(a), W'(b));
        wait_done();
      end
    end

    // Random operands with random idle gaps.
    repeat (24) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_div4_seq

// File: doc/div4_seq.md
# div4_seq

Sequential unsigned restoring divider. It is the inverse-operation companion to the combinational partial-product multiplier and the ripple adders in the arithmetic library. It takes a WIDTH-bit dividend and divisor and produces a quotient and remainder, one bit per clock. A start/busy/done handshake lets it sit behind a register file or a control FSM in the same datapath.

## Interface
- WIDTH, 4, operand, quotient and remainder width; legal range 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  unsigned dividend; captured with start
- divisor  input  WIDTH  unsigned divisor; captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result; held until the next accepted start
- remainder  output  WIDTH  result; held until the next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

## Operation
- States:
  - IDLE: reset state.
  - RUN: WIDTH iterations, counted by an iteration counter of width clog2(WIDTH+1).
  - DONE: lasts exactly 1 cycle, then returns to IDLE.
- IDLE or DONE, with start=1:
  - Latch the operands.
  - Clear quotient, remainder and div_by_zero.
  - If divisor==0, go to DONE. Otherwise go to RUN with counter=0 and partial remainder P=0.
- RUN, each cycle:
  - P' = {P[WIDTH-2:0], Q[WIDTH-1]}, where Q is the dividend/quotient shift register.
  - Shift Q left by 1.
  - T = P' - divisor, computed at WIDTH+1 bits.
  - If there is no borrow: P=T and Q[0]=1. Otherwise: P=P' and Q[0]=0.
  - Increment the counter. After the WIDTH-th iteration, go to DONE.
- DONE:
  - done=1 and busy=0.
  - quotient=Q, remainder=P.
- Divide by zero:
  - quotient = all ones.
  - remainder = dividend.
  - div_by_zero = 1.
- start while in RUN is ignored. The operands are not re-sampled.
- Back-to-back: a start in the DONE cycle is accepted. The next operation begins with no IDLE cycle in between.
- Results are only defined while done=1 and afterwards. quotient and remainder do not change until the next accepted start.
- Arithmetic:
  - All values are unsigned.
  - The invariant dividend = quotient*divisor + remainder holds, with remainder < divisor for every divisor != 0.

## Timing
- Reset (asynchronous on rst_n low, takes effect immediately):
  - state = IDLE.
  - busy, done, div_by_zero, quotient and remainder are all 0.
  - Any in-flight operation is discarded. No done is issued for it.
- Let E0 be the clock edge at which start is accepted.
  - Nonzero divisor: busy is high from after E0 through after E(WIDTH−1). done is high for the one cycle after E(WIDTH). Latency is WIDTH cycles start-to-done, which is 4 at the default.
  - Zero divisor: done and div_by_zero are high in the cycle after E0. busy stays 0. Latency is 1 cycle.
- busy and done are never high at the same time.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package div_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the default-width localparam.
- Sub-module trial_sub is a (WIDTH+1)-bit subtractor that returns the difference and a borrow flag. It reuses the ripple full-adder cell with the divisor inverted and carry-in = 1.
- The top level holds the FSM, the counter and the P/Q shift registers.

## Test plan
- dividend=13, divisor=3 → done exactly 4 cycles after start; quotient=4, remainder=1, div_by_zero=0.
- dividend=3, divisor=7 → quotient=0, remainder=3. Also 15/1 → quotient=15, remainder=0.
- dividend=9, divisor=0 → done 1 cycle after start, busy never high; quotient=15, remainder=9, div_by_zero=1.
- Protocol: start 12/5, then assert start with 15/15 during busy → the second start is ignored and the result is 2 r 2. Then start 15/15 in the DONE cycle → 1 r 0 with no idle gap.
- rst_n low mid-RUN → all outputs 0 immediately, no done pulse; a new 7/2 after release yields 3 r 1.
- Exhaustive: all 256 pairs at WIDTH=4 checked against a reference model, including the invariant and the latency.
